// File: rtl/cve2_prefetch_ctrl.sv
// Instruction-side prefetch sequencer: issues word-aligned fetch requests, tracks
// outstanding responses and drops the ones made stale by a branch.
module cve2_prefetch_ctrl_chk #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_req_i,
  input  logic                instr_gnt_i,
  input  logic [31:0]         instr_addr_i,
  input  logic                instr_rvalid_i,
  input  logic [NUM_REQS-1:0] slot_valid_i
);

  rvalid_has_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> slot_valid_i[0]);

  outstanding_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $countones(slot_valid_i) <= NUM_REQS);

  push_has_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_i && instr_gnt_i && !instr_rvalid_i) |-> !slot_valid_i[NUM_REQS-1]);

  req_held_until_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_i && !instr_gnt_i) |=> (instr_req_i && $stable(instr_addr_i)));

endmodule

module cve2_prefetch_ctrl #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  localparam int            CW         = $clog2(2 * NUM_REQS + 1);
  localparam logic [CW-1:0] NUM_REQS_C = CW'(NUM_REQS);

  function automatic logic [CW-1:0] popcount(input logic [NUM_REQS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < NUM_REQS; i++) begin
      cnt = cnt + {{(CW-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  logic [31:2]         fetch_addr_q, fetch_addr_d;
  logic [31:2]         stored_addr_q, stored_addr_d;
  logic                valid_req_q, valid_req_d;
  logic                discard_req_q, discard_req_d;
  logic [NUM_REQS-1:0] slot_valid_q, slot_valid_d;
  logic [NUM_REQS-1:0] slot_discard_q, slot_discard_d;

  logic [CW-1:0]       out_cnt_s, occ_s;
  logic                free_s, valid_new_req_s, gnt_s, push_discard_s;
  logic [31:2]         req_addr_s;
  logic [NUM_REQS-1:0] disc_br_s, valid_sh_s, disc_sh_s, first_free_s;

  // Throttle: the FIFO is cleared on a branch, so its occupancy does not count then
  always_comb begin
    out_cnt_s = popcount(slot_valid_q);
    occ_s     = popcount(fifo_busy_i) + out_cnt_s;
    if (branch_i) begin
      free_s = (out_cnt_s < NUM_REQS_C);
    end else begin
      free_s = (occ_s < NUM_REQS_C);
    end
  end

  assign valid_new_req_s = req_i & (free_s | branch_i) & ~slot_valid_q[NUM_REQS-1];
  assign instr_req_o     = valid_req_q | valid_new_req_s;
  assign gnt_s           = instr_req_o & instr_gnt_i;
  // A granted slot is stale only if its address predates the current branch
  assign push_discard_s  = discard_req_q | (branch_i & valid_req_q);

  // Request address: a held request must stay stable until granted
  always_comb begin
    if (valid_req_q) begin
      req_addr_s = stored_addr_q;
    end else if (branch_i) begin
      req_addr_s = addr_i[31:2];
    end else begin
      req_addr_s = fetch_addr_q;
    end
  end

  assign instr_addr_o = {req_addr_s, 2'b00};

  // Next state for the pending request and the fetch pointer
  always_comb begin
    valid_req_d   = instr_req_o & ~instr_gnt_i;
    discard_req_d = valid_req_q & ~instr_gnt_i & (discard_req_q | branch_i);
    if (valid_req_q) begin
      stored_addr_d = stored_addr_q;
    end else begin
      stored_addr_d = req_addr_s;
    end
    if (gnt_s & ~push_discard_s) begin
      fetch_addr_d = req_addr_s + 30'd1;
    end else if (branch_i) begin
      fetch_addr_d = addr_i[31:2];
    end else begin
      fetch_addr_d = fetch_addr_q;
    end
  end

  // Outstanding slots: mark stale on branch, pop on response, push into first free slot
  always_comb begin
    disc_br_s = slot_discard_q | (slot_valid_q & {NUM_REQS{branch_i}});
    if (instr_rvalid_i) begin
      valid_sh_s = {1'b0, slot_valid_q[NUM_REQS-1:1]};
      disc_sh_s  = {1'b0, disc_br_s[NUM_REQS-1:1]};
    end else begin
      valid_sh_s = slot_valid_q;
      disc_sh_s  = disc_br_s;
    end
    first_free_s = ~valid_sh_s & {valid_sh_s[NUM_REQS-2:0], 1'b1};
    if (gnt_s) begin
      slot_valid_d   = valid_sh_s | first_free_s;
      slot_discard_d = (disc_sh_s & valid_sh_s) | (first_free_s & {NUM_REQS{push_discard_s}});
    end else begin
      slot_valid_d   = valid_sh_s;
      slot_discard_d = disc_sh_s & valid_sh_s;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q   <= 30'd0;
      stored_addr_q  <= 30'd0;
      valid_req_q    <= 1'b0;
      discard_req_q  <= 1'b0;
      slot_valid_q   <= {NUM_REQS{1'b0}};
      slot_discard_q <= {NUM_REQS{1'b0}};
    end else begin
      fetch_addr_q   <= fetch_addr_d;
      stored_addr_q  <= stored_addr_d;
      valid_req_q    <= valid_req_d;
      discard_req_q  <= discard_req_d;
      slot_valid_q   <= slot_valid_d;
      slot_discard_q <= slot_discard_d;
    end
  end

  assign fifo_valid_o = instr_rvalid_i & ~slot_discard_q[0] & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_i ? addr_i : {fetch_addr_q, 2'b00};
  assign busy_o       = valid_req_q | (|slot_valid_q);

  cve2_prefetch_ctrl_chk #(
    .NUM_REQS (NUM_REQS)
  ) u_chk (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_i   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .slot_valid_i   (slot_valid_q)
  );

endmodule

// File: tb/tb_cve2_prefetch_ctrl.sv
// Directed bench for cve2_prefetch_ctrl: a queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_cve2_prefetch_ctrl;

  localparam int NUM_REQS = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                req_i, branch_i;
  logic [31:0]         addr_i;
  logic                busy_o;
  logic [NUM_REQS-1:0] fifo_busy_i;
  logic                fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [31:0]         fifo_addr_o, fifo_rdata_o;
  logic                instr_req_o, instr_gnt_i;
  logic [31:0]         instr_addr_o;
  logic                instr_rvalid_i;
  logic [31:0]         instr_rdata_i;
  logic                instr_err_i;

  cve2_prefetch_ctrl #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .busy_o         (busy_o),
    .fifo_busy_i    (fifo_busy_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory side: addresses granted and not yet answered, oldest first
  logic [31:0] memq[$];

  task automatic drv(input logic rq, input logic br, input logic [31:0] a,
                     input logic [1:0] fb, input logic g, input logic rs, input logic e);
    @(posedge clk_i);
    #1;
    req_i          = rq;
    branch_i       = br;
    addr_i         = a;
    fifo_busy_i    = fb;
    instr_gnt_i    = g;
    instr_rvalid_i = rs && (memq.size() > 0);
    instr_rdata_i  = instr_rvalid_i ? data_of(memq[0]) : 32'h0;
    instr_err_i    = e;
    @(negedge clk_i);
    if (instr_rvalid_i) void'(memq.pop_front());
    if (instr_req_o && instr_gnt_i) memq.push_back(instr_addr_o);
  endtask

  // Reference model: next word, pending request, queue of outstanding fetches
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } slot_t;

  slot_t       outq[$];
  logic [31:0] m_next = 32'h0;
  logic [31:0] m_pend_addr = 32'h0;
  bit          m_pend = 1'b0;
  bit          m_pend_stale = 1'b0;

  initial begin
    int          n_out, busy_cnt;
    bit          m_free, m_new, e_req, e_valid, head_stale, granted, push_stale;
    logic [31:0] e_addr, head_addr;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_next = 32'h0; m_pend = 1'b0; m_pend_addr = 32'h0; m_pend_stale = 1'b0;
        outq.delete();
      end
      n_out    = outq.size();
      busy_cnt = $countones(fifo_busy_i);
      m_free   = branch_i ? (n_out < NUM_REQS) : (busy_cnt + n_out < NUM_REQS);
      m_new    = req_i && (m_free || branch_i) && (n_out < NUM_REQS);
      e_req    = m_pend || m_new;
      e_addr   = m_pend ? m_pend_addr : (branch_i ? {addr_i[31:2], 2'b00} : m_next);
      head_stale = (n_out > 0) ? outq[0].stale : 1'b1;
      head_addr  = (n_out > 0) ? outq[0].addr : 32'h0;
      e_valid  = instr_rvalid_i && !head_stale && !branch_i;

      chk("model instr_req_o", instr_req_o, e_req);
      chk("model instr_addr_o", instr_addr_o, e_addr);
      chk("model fifo_clear_o", fifo_clear_o, branch_i);
      chk("model fifo_addr_o", fifo_addr_o, branch_i ? addr_i : m_next);
      chk("model busy_o", busy_o, m_pend || (n_out > 0));
      chk("model fifo_valid_o", fifo_valid_o, e_valid);
      if (e_valid) begin
        chk("model fifo_rdata_o", fifo_rdata_o, data_of(head_addr));
        chk("model fifo_err_o", fifo_err_o, instr_err_i);
      end

      granted    = e_req && instr_gnt_i;
      push_stale = m_pend_stale || (branch_i && m_pend);
      if (branch_i) foreach (outq[i]) outq[i].stale = 1'b1;
      if (instr_rvalid_i && n_out > 0) void'(outq.pop_front());
      if (granted) outq.push_back('{e_addr, push_stale});
      if (granted && !push_stale) m_next = e_addr + 32'd4;
      else if (branch_i) m_next = {addr_i[31:2], 2'b00};
      if (granted) begin
        m_pend = 1'b0; m_pend_stale = 1'b0;
      end else if (e_req) begin
        if (m_pend) m_pend_stale = m_pend_stale || branch_i;
        else begin
          m_pend = 1'b1; m_pend_addr = e_addr; m_pend_stale = 1'b0;
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; addr_i = 32'h0; fifo_busy_i = 2'b00;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; instr_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset instr_req_o", instr_req_o, 1'b0);
    chk("reset busy_o", busy_o, 1'b0);
    chk("reset instr_addr_o", instr_addr_o, 32'h0);
    chk("reset fifo_valid_o", fifo_valid_o, 1'b0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    drv(0, 0, 32'h0, 2'b00, 0, 0, 0);
    chk("idle instr_addr_o", instr_addr_o, 32'h0);

    // Straight-line fetch from 0x100
    drv(1, 1, 32'h100, 2'b00, 1, 1, 0);
    chk("line first req", instr_req_o, 1'b1);
    chk("line first addr", instr_addr_o, 32'h100);
    chk("line clear", fifo_clear_o, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      drv(1, 0, 32'h0, 2'b00, 1, 1, 0);
      chk("line addr", instr_addr_o, 32'h100 + 32'(4 * k));
      chk("line fifo_valid", fifo_valid_o, 1'b1);
      chk("line rdata", fifo_rdata_o, data_of(32'h100 + 32'(4 * (k - 1))));
    end
    drv(0, 0, 32'h0, 2'b00, 0, 1, 0);
    chk("line last rdata", fifo_rdata_o, data_of(32'h118));
    drv(0, 0, 32'h0, 2'b00, 0, 0, 0);
    chk("line idle busy", busy_o, 1'b0);

    // Throttle against FIFO occupancy
    drv(1, 1, 32'h40, 2'b11, 1, 0, 0);
    chk("thr branch addr", instr_addr_o, 32'h40);
    repeat (2) begin
      drv(1, 0, 32'h0, 2'b11, 1, 0, 0);
      chk("thr full req", instr_req_o, 1'b0);
    end
    drv(1, 0, 32'h0, 2'b00, 1, 0, 0);
    chk("thr resume addr", instr_addr_o, 32'h44);
    drv(1, 0, 32'h0, 2'b00, 1, 0, 0);
    chk("thr two out req", instr_req_o, 1'b0);
    drv(1, 0, 32'h0, 2'b00, 1, 1, 0);
    chk("thr pop cycle req", instr_req_o, 1'b0);
    chk("thr pop valid", fifo_valid_o, 1'b1);
    drv(1, 0, 32'h0, 2'b00, 1, 0, 0);
    chk("thr after pop req", instr_req_o, 1'b1);
    chk("thr after pop addr", instr_addr_o, 32'h48);
    drv(0, 0, 32'h0, 2'b00, 0, 1, 0);
    drv(0, 0, 32'h0, 2'b00, 0, 1, 0);
    chk("thr last rdata", fifo_rdata_o, data_of(32'h48));
    drv(0, 0, 32'h0, 2'b00, 0, 0, 0);
    chk("thr idle busy", busy_o, 1'b0);

    // Branch with two outstanding
    drv(1, 1, 32'h200, 2'b00, 1, 0, 0);
    drv(1, 0, 32'h0, 2'b00, 1, 0, 0);
    chk("br2 second addr", instr_addr_o, 32'h204);
    drv(1, 1, 32'h402, 2'b00, 1, 1, 0);
    chk("br2 clear", fifo_clear_o, 1'b1);
    chk("br2 fifo_addr", fifo_addr_o, 32'h402);
    chk("br2 0x200 dropped", fifo_valid_o, 1'b0);
    drv(1, 0, 32'h0, 2'b00, 1, 1, 0);
    chk("br2 target req", instr_req_o, 1'b1);
    chk("br2 target addr", instr_addr_o, 32'h400);
    chk("br2 0x204 dropped", fifo_valid_o, 1'b0);
    drv(0, 0, 32'h0, 2'b00, 0, 1, 0);
    chk("br2 0x400 valid", fifo_valid_o, 1'b1);
    chk("br2 0x400 rdata", fifo_rdata_o, data_of(32'h400));
    drv(0, 0, 32'h0, 2'b00, 0, 0, 0);
    chk("br2 idle busy", busy_o, 1'b0);

    // Branch while a request waits for grant
    drv(1, 1, 32'h300, 2'b00, 0, 0, 0);
    chk("pend addr c1", instr_addr_o, 32'h300);
    drv(1, 1, 32'h500, 2'b00, 0, 0, 0);
    chk("pend addr c2", instr_addr_o, 32'h300);
    chk("pend fifo_addr", fifo_addr_o, 32'h500);
    drv(1, 0, 32'h0, 2'b00, 0, 0, 0);
    chk("pend addr c3", instr_addr_o, 32'h300);
    drv(1, 0, 32'h0, 2'b00, 1, 0, 0);
    chk("pend addr gnt", instr_addr_o, 32'h300);
    drv(1, 0, 32'h0, 2'b00, 1, 1, 0);
    chk("pend next addr", instr_addr_o, 32'h500);
    chk("pend 0x300 dropped", fifo_valid_o, 1'b0);
    drv(0, 0, 32'h0, 2'b00, 0, 1, 0);
    chk("pend 0x500 valid", fifo_valid_o, 1'b1);
    chk("pend 0x500 rdata", fifo_rdata_o, data_of(32'h500));
    drv(0, 0, 32'h0, 2'b00, 0, 0, 0);
    chk("pend idle busy", busy_o, 1'b0);

    // Discard ordering, push/pop in one cycle, error passthrough
    drv(1, 1, 32'h600, 2'b00, 1, 0, 0);
    drv(1, 0, 32'h0, 2'b00, 1, 1, 0);
    chk("pp 0x604 addr", instr_addr_o, 32'h604);
    chk("pp 0x600 valid", fifo_valid_o, 1'b1);
    drv(1, 1, 32'h800, 2'b00, 1, 0, 0);
    chk("pp branch addr", instr_addr_o, 32'h800);
    drv(1, 0, 32'h0, 2'b00, 1, 1, 0);
    chk("pp full req", instr_req_o, 1'b0);
    chk("pp 0x604 dropped", fifo_valid_o, 1'b0);
    drv(1, 0, 32'h0, 2'b00, 1, 1, 1);
    chk("pp push addr", instr_addr_o, 32'h804);
    chk("pp 0x800 valid", fifo_valid_o, 1'b1);
    chk("pp 0x800 err", fifo_err_o, 1'b1);
    chk("pp 0x800 rdata", fifo_rdata_o, data_of(32'h800));
    drv(0, 0, 32'h0, 2'b00, 0, 1, 0);
    chk("pp 0x804 valid", fifo_valid_o, 1'b1);
    chk("pp 0x804 rdata", fifo_rdata_o, data_of(32'h804));
    chk("pp busy last", busy_o, 1'b1);
    drv(0, 0, 32'h0, 2'b00, 0, 0, 0);
    chk("pp idle busy", busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
